// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle main control FSM.
// Opcode, opsc and pc_src encodings are common to the controller and its decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } ctrl_state_e;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_ANDI  = 4'b0101;
    localparam logic [3:0] OP_J     = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [2:0] OPSC_ADD  = 3'b000;
    localparam logic [2:0] OPSC_SUB  = 3'b001;
    localparam logic [2:0] OPSC_AND  = 3'b010;
    localparam logic [2:0] OPSC_FUNC = 3'b100;

    localparam logic [1:0] PC_SRC_INC = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             reg_we;
    logic             wb_sel;
    logic             alu_srcb;
    logic [2:0]       opsc;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, wb_sel, alu_srcb, opsc,
               halted, illegal, instr_cnt
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, wb_sel, alu_srcb, opsc,
               halted, illegal, instr_cnt
    );
endinterface

// File: rtl/ctrl_opsc_dec.sv
// Opcode decoder: ALU op-select, immediate-operand select and legality.
module ctrl_opsc_dec
    import ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] opsc,
    output logic       alu_srcb,
    output logic       legal
);
    always_comb begin
        opsc     = OPSC_ADD;
        alu_srcb = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OP_RTYPE:            opsc = OPSC_FUNC;
            OP_ADDI, OP_LW, OP_SW: alu_srcb = 1'b1;
            OP_BEQ:              opsc = OPSC_SUB;
            OP_ANDI: begin
                opsc     = OPSC_AND;
                alu_srcb = 1'b1;
            end
            OP_J, OP_HALT:       ;
            default:             legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: fetch/decode/exec/mem/wb sequencing and memory handshake.
// Define MULTICYCLE_CTRL_INSTR_CNT_EN to build the retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    ctrl_state_e state_q, state_d;
    logic [3:0]  op_q;
    logic [3:0]  dec_op;
    logic [2:0]  dec_opsc;
    logic        dec_alu_srcb;
    logic        dec_legal;
    logic        illegal_q;
    logic        set_illegal;
    logic        retire;

    // Live opcode while decoding, latched copy for the rest of the instruction.
    assign dec_op = (state_q == StDecode) ? bus.opcode : op_q;

    ctrl_opsc_dec u_dec (
        .opcode   (dec_op),
        .opsc     (dec_opsc),
        .alu_srcb (dec_alu_srcb),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) op_q <= bus.opcode;
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.ir_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.pc_src   = PC_SRC_INC;
        bus.reg_we   = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.alu_srcb = 1'b0;
        bus.opsc     = OPSC_ADD;
        bus.halted   = 1'b0;
        set_illegal  = 1'b0;
        retire       = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                if (bus.opcode == OP_J) begin
                    bus.pc_we  = 1'b1;
                    bus.pc_src = PC_SRC_JMP;
                    retire     = 1'b1;
                    state_d    = StFetch;
                end else if (bus.opcode == OP_HALT) begin
                    state_d = StHalt;
                end else if (!dec_legal) begin
                    set_illegal = 1'b1;
                    state_d     = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                bus.opsc     = dec_opsc;
                bus.alu_srcb = dec_alu_srcb;
                if (op_q == OP_BEQ) begin
                    bus.pc_we  = bus.zero;
                    bus.pc_src = PC_SRC_BR;
                    retire     = 1'b1;
                    state_d    = StFetch;
                end else if (op_q == OP_LW || op_q == OP_SW) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = (op_q == OP_SW);
                if (bus.mem_ready) begin
                    retire  = (op_q == OP_SW);
                    state_d = (op_q == OP_SW) ? StFetch : StWb;
                end
            end
            StWb: begin
                bus.reg_we = 1'b1;
                bus.wb_sel = (op_q == OP_LW);
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StHalt: bus.halted = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    assign bus.illegal = illegal_q;

`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.instr_cnt = cnt_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign bus.instr_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-instruction cycle-schedule model.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SCNT_W = 4;

    localparam int K_FREE   = 0;
    localparam int K_WAIT   = 1;
    localparam int K_READY  = 2;
    localparam int K_DECODE = 3;
    localparam int K_EXEC   = 4;

    typedef struct {
        logic [13:0] exp;
        int          kind;
        bit          retire;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
    multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    // Second, narrow-counter instance used only to observe counter wrap in a short run.
    multicycle_ctrl_if #(.CNT_W(SCNT_W)) sbus ();
    multicycle_ctrl #(.CNT_W(SCNT_W)) dut_s (.clk(clk), .rst(rst_s), .bus(sbus.master));

    logic [13:0] act;
    assign act = {bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.pc_src, bus.reg_we,
                  bus.wb_sel, bus.alu_srcb, bus.opsc, bus.halted, bus.illegal};

    int checks = 0;
    int passed = 0;
    item_t sched[$];
    logic [3:0] cur_op;
    logic cur_z;
    logic [CNT_W-1:0] cnt_m;

    function automatic logic [13:0] ov(input logic mreq, input logic mwe, input logic irwe,
                                       input logic pcwe, input logic [1:0] psrc, input logic rwe,
                                       input logic wbs, input logic asb, input logic [2:0] opsc,
                                       input logic h, input logic il);
        return {mreq, mwe, irwe, pcwe, psrc, rwe, wbs, asb, opsc, h, il};
    endfunction

    function automatic logic [CNT_W-1:0] cnt_exp();
`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
        return cnt_m;
`else
        return '0;
`endif
    endfunction

    function automatic logic [SCNT_W-1:0] scnt_exp(input int retired);
`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
        return SCNT_W'(retired % (1 << SCNT_W));
`else
        return '0;
`endif
    endfunction

    task automatic push(input logic [13:0] e, input int k, input bit r);
        item_t it;
        it.exp = e;
        it.kind = k;
        it.retire = r;
        sched.push_back(it);
    endtask

    task automatic push_fetch(input int fw);
        for (int i = 0; i < fw; i++) push(ov(1, 0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 0, 0), K_WAIT, 0);
        push(ov(1, 0, 1, 1, PC_SRC_INC, 0, 0, 0, OPSC_ADD, 0, 0), K_READY, 0);
    endtask

    // Expected per-cycle outputs for one instruction, built from the opcode table and timing.
    task automatic plan(input logic [3:0] op, input logic z, input int fw, input int mw);
        logic [2:0] opsc;
        logic asb;
        bit sw;
        sched.delete();
        cur_op = op;
        cur_z = z;
        push_fetch(fw);
        if (op == OP_J) begin
            push(ov(0, 0, 0, 1, PC_SRC_JMP, 0, 0, 0, 3'd0, 0, 0), K_DECODE, 1);
            return;
        end
        push(14'd0, K_DECODE, 0);
        case (op)
            OP_RTYPE: begin opsc = 3'b100; asb = 0; end
            OP_BEQ:   begin opsc = 3'b001; asb = 0; end
            OP_ANDI:  begin opsc = 3'b010; asb = 1; end
            default:  begin opsc = 3'b000; asb = 1; end
        endcase
        if (op == OP_BEQ) begin
            push(ov(0, 0, 0, z, PC_SRC_BR, 0, 0, 0, opsc, 0, 0), K_EXEC, 1);
            return;
        end
        push(ov(0, 0, 0, 0, 2'd0, 0, 0, asb, opsc, 0, 0), K_EXEC, 0);
        if (op == OP_LW || op == OP_SW) begin
            sw = (op == OP_SW);
            for (int i = 0; i < mw; i++) push(ov(1, sw, 0, 0, 2'd0, 0, 0, 0, 3'd0, 0, 0), K_WAIT, 0);
            push(ov(1, sw, 0, 0, 2'd0, 0, 0, 0, 3'd0, 0, 0), K_READY, sw);
            if (sw) return;
        end
        push(ov(0, 0, 0, 0, 2'd0, 1, op == OP_LW, 0, 3'd0, 0, 0), K_FREE, 1);
    endtask

    task automatic plan_halt(input logic [3:0] op, input int fw);
        bit il;
        sched.delete();
        cur_op = op;
        cur_z = 1'b0;
        il = (op != OP_HALT);
        push_fetch(fw);
        push(14'd0, K_DECODE, 0);
        for (int i = 0; i < 20; i++) push(ov(0, 0, 0, 0, 2'd0, 0, 0, 0, 3'd0, 1, il), K_FREE, 0);
    endtask

    // Plays the first n scheduled cycles; inputs not under test carry random noise.
    task automatic run(input string name, input int n);
        for (int i = 0; i < n && i < sched.size(); i++) begin
            @(negedge clk);
            bus.opcode = 4'($urandom);
            bus.zero = 1'($urandom);
            bus.mem_ready = 1'($urandom);
            case (sched[i].kind)
                K_WAIT:   bus.mem_ready = 1'b0;
                K_READY:  bus.mem_ready = 1'b1;
                K_DECODE: bus.opcode = cur_op;
                K_EXEC:   bus.zero = cur_z;
                default:  ;
            endcase
            #1;
            checks++;
            if (act !== sched[i].exp)
                $display("FAIL %s cycle %0d outputs: got %b expected %b", name, i, act,
                         sched[i].exp);
            else passed++;
            checks++;
            if (bus.instr_cnt !== cnt_exp())
                $display("FAIL %s cycle %0d instr_cnt: got %0d expected %0d", name, i,
                         bus.instr_cnt, cnt_exp());
            else passed++;
            if (sched[i].retire) cnt_m = cnt_m + 1'b1;
        end
    endtask

    task automatic run_all(input string name);
        run(name, sched.size());
    endtask

    task automatic test_reset(input string name);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (act !== 14'd0) $display("FAIL %s async: got %b expected 0", name, act);
        else passed++;
        checks++;
        if (bus.instr_cnt !== '0) $display("FAIL %s cnt: got %0d expected 0", name, bus.instr_cnt);
        else passed++;
        cnt_m = '0;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.opcode = 4'($urandom);
        rst = 1'b0;
        #1;
        checks++;
        if (act !== 14'd0) $display("FAIL %s idle: got %b expected 0", name, act);
        else passed++;
    endtask

    task automatic check_cnt(input string name);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.instr_cnt !== cnt_exp())
            $display("FAIL %s: got %0d expected %0d", name, bus.instr_cnt, cnt_exp());
        else passed++;
    endtask

    task automatic test_addi();
        test_reset("reset_addi");
        plan(OP_ADDI, 1'b0, 0, 0);
        run_all("addi");
        check_cnt("addi_cnt");
    endtask

    task automatic test_lw_wait();
        test_reset("reset_lw");
        plan(OP_LW, 1'b0, 0, 2);
        run_all("lw_wait");
        check_cnt("lw_cnt");
    endtask

    task automatic test_beq();
        test_reset("reset_beq");
        plan(OP_BEQ, 1'b1, 0, 0);
        run_all("beq_taken");
        plan(OP_BEQ, 1'b0, 0, 0);
        run_all("beq_not_taken");
        check_cnt("beq_cnt");
    endtask

    task automatic test_halt();
        test_reset("reset_ill");
        plan_halt(4'b1010, 0);
        run_all("illegal_1010");
        test_reset("reset_ill_rand");
        plan_halt(4'($urandom_range(7, 14)), 1);
        run_all("illegal_rand");
        test_reset("reset_halt");
        plan_halt(OP_HALT, 0);
        run_all("halt_op");
    endtask

    task automatic test_reset_mid_mem();
        test_reset("reset_sw");
        plan(OP_SW, 1'b0, 0, 5);
        run("sw_wait", 5);
        test_reset("reset_mid_mem");
        plan(OP_ADDI, 1'b0, 0, 0);
        run_all("after_mid_reset");
    endtask

    task automatic test_random();
        logic [3:0] ops [7] = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_ANDI, OP_J};
        test_reset("reset_rand");
        for (int n = 0; n < 150; n++) begin
            plan(ops[$urandom_range(0, 6)], 1'($urandom), $urandom_range(0, 2),
                 $urandom_range(0, 2));
            run_all("random");
        end
        check_cnt("random_cnt");
    endtask

    task automatic test_cnt_wrap();
        int retired;
        @(negedge clk);
        rst_s = 1'b0;
        retired = 0;
        // Idle cycle, then each J retires every two cycles.
        repeat (1) @(posedge clk);
        for (int k = 1; k <= 17; k++) begin
            repeat (2) @(posedge clk);
            retired++;
            #1;
            if (k == 1 || k == 15 || k == 16 || k == 17) begin
                checks++;
                if (sbus.instr_cnt !== scnt_exp(retired))
                    $display("FAIL cnt_wrap after %0d: got %0d expected %0d", retired,
                             sbus.instr_cnt, scnt_exp(retired));
                else passed++;
            end
        end
    endtask

    initial begin
        bus.opcode = 4'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        sbus.opcode = OP_J;
        sbus.zero = 1'b0;
        sbus.mem_ready = 1'b1;
        cnt_m = '0;
        repeat (2) @(negedge clk);
        test_addi();
        test_lw_wait();
        test_beq();
        test_halt();
        test_reset_mid_mem();
        test_random();
        test_cnt_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main control FSM for the CPU datapath. Decodes the 4-bit instruction opcode and sequences fetch, decode, execute, memory and write-back. In each step it drives the register-file, PC, IR and memory enables, plus the 3-bit `opsc` that feeds the ALU control decoder. It sits between the instruction register and the datapath and is the only block that owns the memory request handshake.

## Interface
Parameters:
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk`: in, 1, sole clock; all state updates on the rising edge.
- `rst`: in, 1, asynchronous, active-high reset.
- `opcode`: in, 4, `IR[15:12]`; sampled in DECODE.
- `zero`: in, 1, ALU zero flag; sampled in EXEC.
- `mem_ready`: in, 1, memory completes the current request this cycle.
- `mem_req`: out, 1, memory request.
- `mem_we`: out, 1, write qualifier for `mem_req`.
- `ir_we`: out, 1, load IR.
- `pc_we`: out, 1, load PC.
- `pc_src`: out, 2, PC source: 0 = PC+1, 1 = branch target, 2 = jump target.
- `reg_we`: out, 1, register-file write.
- `wb_sel`: out, 1, write-back source: 0 = ALU, 1 = memory.
- `alu_srcb`: out, 1, ALU B operand: 0 = register, 1 = immediate.
- `opsc`: out, 3, op-select to the ALU control decoder.
- `halted`: out, 1, FSM is in HALT.
- `illegal`: out, 1, sticky flag; set by an undefined opcode.
- `instr_cnt`: out, `CNT_W`, retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset values:
  - State is IDLE.
  - Every output is 0, including `illegal` and `instr_cnt`.
- IDLE → FETCH unconditionally on the next cycle.
- FETCH:
  - `mem_req` = 1, `mem_we` = 0.
  - Held until `mem_ready` = 1.
  - In the `mem_ready` cycle: `ir_we` = 1, `pc_we` = 1, `pc_src` = 0, then → DECODE.
- DECODE transitions:
  - J (0110): `pc_we` = 1, `pc_src` = 2, → FETCH.
  - HALT (1111): → HALT.
  - Undefined opcode: set `illegal`, → HALT.
  - All others: → EXEC.
- EXEC `opsc` by opcode:
  - R-type (0000): `opsc` = 100.
  - ADDI (0001), LW (0010), SW (0011): `opsc` = 000, `alu_srcb` = 1.
  - BEQ (0100): `opsc` = 001.
  - ANDI (0101): `opsc` = 010, `alu_srcb` = 1.
- `opsc` is 000 in every state other than EXEC.
- EXEC transitions:
  - BEQ: `pc_we` = `zero`, `pc_src` = 1, → FETCH.
  - LW, SW: → MEM.
  - All others: → WB.
- MEM:
  - `mem_req` = 1; `mem_we` = 1 for SW.
  - Held until `mem_ready` = 1.
  - SW → FETCH; LW → WB.
- WB:
  - `reg_we` = 1 for one cycle.
  - `wb_sel` = 1 for LW, 0 otherwise.
  - → FETCH.
- HALT:
  - Absorbing; `halted` = 1; all enables are 0.
  - Only `rst` exits.
- An instruction retires in its last state (the state that returns to FETCH). `instr_cnt` increments by 1 on that edge and wraps from all-ones to 0.

## Timing
- State is registered. Outputs are combinational from state, latched opcode and the `mem_ready`/`zero` inputs; there is no output register.
- The opcode is latched in DECODE and held through the end of the instruction.
- Cycle counts with zero-wait memory (`mem_ready` high in the first request cycle), FETCH included:
  - J: 2. BEQ: 3.
  - R-type, ADDI, ANDI, SW: 4.
  - LW: 5.
- Each wait cycle adds 1.
- `mem_req` stays high and `mem_we` stays stable until the `mem_ready` cycle. `mem_ready` is ignored whenever `mem_req` = 0.
- At most one of `ir_we`, `reg_we`, memory write is active per cycle. `pc_we` coincides with `ir_we` only in FETCH.
- `rst` asserted mid-instruction, including during a MEM wait:
  - State goes to IDLE immediately.
  - `mem_req` and all enables drop asynchronously.
  - The pending memory access is abandoned.

## Configuration
- `MULTICYCLE_CTRL_INSTR_CNT_EN`:
  - Defined: the `instr_cnt` counter is built as described under Operation.
  - Undefined: no counter flops; `instr_cnt` is tied to 0.
- The port list is identical in both builds.

## Structure
- Shared package `ctrl_pkg`:
  - state encoding enum;
  - opcode constants `OP_RTYPE` … `OP_HALT`;
  - `opsc` constants `OPSC_ADD` = 000, `OPSC_SUB` = 001, `OPSC_AND` = 010, `OPSC_FUNC` = 100;
  - `pc_src` constants.
- One sub-module, `ctrl_opsc_dec`: combinational opcode → {`opsc`, `alu_srcb`, legal}. It is instantiated once and used in DECODE/EXEC.

## Test plan
- Reset release, then ADDI with `mem_ready` tied high → `opsc` = 000 and `alu_srcb` = 1 in cycle 3, `reg_we` = 1 in cycle 4, `instr_cnt` = 1.
- LW with `mem_ready` low for 2 MEM cycles → `mem_req` held 3 cycles at `mem_we` = 0, `wb_sel` = 1 in WB, 7 cycles total.
- BEQ with `zero` = 1, then BEQ with `zero` = 0 → `pc_we` = 1 / `pc_src` = 1 in the first EXEC, `pc_we` = 0 in the second; each instruction takes 3 cycles.
- Opcode 1010 → `illegal` = 1, `halted` = 1 from the next cycle, `mem_req` stays 0 for 20 cycles.
- `rst` pulsed during an SW MEM wait → `mem_req` and `mem_we` fall within the reset cycle, state IDLE, FETCH one cycle after release.
- Build with the macro, preload 65535 retirements, retire one more → `instr_cnt` wraps to 0; without the macro `instr_cnt` stays 0 throughout.
